shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
Parametrised universal shift register, the successor to the single-bit D flip-flop.
- WIDTH-bit register supporting hold, parallel load, logical shift, rotate, arithmetic shift and clear.
- Ops run either single-step under a clock enable, or as an automatic N-step sequence with a start/busy/done handshake.
- Datapath building block for serial links, multiply/divide sequencers and lab exercises.

Parameters:
WIDTH, 8, register width in bits (>=2)
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)
CNT_W, 4, width of step-count input; max sequence length 2**CNT_W-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  clock enable for single-step (direct) ops
op  in  3  operation select (codes below)
d  in  WIDTH  parallel load data
sin_l  in  1  serial input entering at LSB on SHL
sin_r  in  1  serial input entering at MSB on SHR
start  in  1  launch multi-step sequence of op, count steps
count  in  CNT_W  number of steps for sequence
q  out  WIDTH  register contents
ser_out  out  1  bit shifted/rotated out by the last shift step
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a start request completes

Behaviour:
- One clock. Reset is synchronous and active-high, with ports named clk and reset; reset has priority over everything.
- Reset values: q=RESET_VAL, ser_out=0, busy=0, done=0.
- Op codes:
  - 000 HOLD; 001 LOAD (q=d); 010 SHL (q={q[W-2:0],sin_l}, ser_out=q[W-1]).
  - 011 SHR (q={sin_r,q[W-1:1]}, ser_out=q[0]).
  - 100 ROL (ser_out=q[W-1]); 101 ROR (ser_out=q[0]).
  - 110 ASR (q={q[W-1],q[W-1:1]}, ser_out=q[0]); 111 CLR (q=0).
- ser_out changes only on SHL/SHR/ROL/ROR/ASR steps; it holds on HOLD/LOAD/CLR.
- Idle (busy=0), start=0, en=1: execute op once at the edge. With en=0, q and ser_out hold.
- Idle, start=1 sampled at edge E0 (start has priority over en):
  - op is HOLD/LOAD/CLR, or count=0: execute the op once at E0 (count=0 with a shift op means no change). done=1 for the cycle after E0; busy stays 0.
  - op is a shift/rotate op and count=N>=1: latch op and N at E0 with no q change, and set busy=1. Perform one step at each of E1..EN. At EN set busy=0 and done=1 for one cycle. Total: busy is high N cycles, then done.
- During busy:
  - start, en, op, count and d are ignored, so a re-start has no effect.
  - sin_l/sin_r are sampled live at each step edge.
- done=0 in all other cycles. A start is accepted again in the cycle done is high.
- Reset mid-sequence aborts: q=RESET_VAL, busy=0, no done pulse.
- Internal step counter is CNT_W bits and decrements to 0; no wrap is possible.

Decomposition:
- Package shift_register_pkg holds:
  - the op-code localparams (OP_HOLD..OP_CLR);
  - the FSM state encodings (S_IDLE, S_RUN).
- One combinational sub-module, shift_unit (WIDTH param):
  - inputs q, op, sin_l, sin_r;
  - outputs next q and shifted-out bit;
  - shared by the direct path and the sequence path.
- Top holds the registers, 2-state FSM and step counter.

Test Plan:
1. Reset: hold reset 2 cycles with en=1, op=LOAD, d=FF -> q=00, ser_out=0, busy=0, done=0.
2. Direct ops, en=1:
   - LOAD d=A5 -> q=A5;
   - SHL sin_l=1 -> q=4B, ser_out=1;
   - SHR sin_r=0 -> q=25, ser_out=1;
   - LOAD 80, then ASR -> q=C0, ser_out=0;
   - en=0 with op=CLR -> q holds C0.
3. Sequence: q=81, start ROL count=3 -> busy high 3 cycles, q 03,06,0C, then done=1 one cycle with busy=0, ser_out=0.
4. Edge cases:
   - start SHR count=0 on q=5A -> done next cycle, busy never 1, q=5A;
   - start while busy (new count=7) -> ignored, original sequence length kept.
5. Abort: q=FF, start SHR count=10 sin_r=0, assert reset after 4 steps -> q=00, busy=0, no done pulse ever.
6. Serial streaming: q=00, start SHL count=8 with sin_l driven 1,0,1,1,0,0,1,0 on successive steps -> q=B2, then done.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared op codes, FSM state encoding and op classification for the universal shift register.
package shift_register_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Only shift/rotate ops produce a serial bit and may run as a multi-step sequence.
  function automatic logic is_shift_op(input logic [2:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational one-step shifter. Non-shift ops pass q through; LOAD/CLR are resolved by the caller.
module shift_unit
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next,
  output logic             sout
);

  always_comb begin
    q_next = q;
    sout   = 1'b0;
    unique case (op)
      OP_SHL: begin
        q_next = {q[WIDTH-2:0], sin_l};
        sout   = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next = {sin_r, q[WIDTH-1:1]};
        sout   = q[0];
      end
      OP_ROL: begin
        q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        sout   = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next = {q[0], q[WIDTH-1:1]};
        sout   = q[0];
      end
      OP_ASR: begin
        q_next = {q[WIDTH-1], q[WIDTH-1:1]};
        sout   = q[0];
      end
      OP_HOLD, OP_LOAD, OP_CLR: begin
        q_next = q;
        sout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: direct single-step ops under en, or an N-step shift sequence
// launched by start with busy/done handshake.
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned     CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               ser_q, ser_d;
  logic               done_q, done_d;

  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   sh_q;
  logic               sh_bit;
  logic [WIDTH-1:0]   direct_q;
  logic               direct_ser;

  // The single shifter serves the latched op while running and the live op while idle.
  assign op_sel = (state_q == S_RUN) ? op_q : op;

  shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .q      (q_q),
    .op     (op_sel),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (sh_q),
    .sout   (sh_bit)
  );

  // Result of executing the live op once.
  always_comb begin
    direct_q   = q_q;
    direct_ser = ser_q;
    case (op)
      OP_HOLD: direct_q = q_q;
      OP_LOAD: direct_q = d;
      OP_CLR:  direct_q = '0;
      default: begin
        direct_q   = sh_q;
        direct_ser = sh_bit;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    ser_d   = ser_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_shift_op(op) && (count != '0)) begin
            op_d    = op;
            cnt_d   = count;
            state_d = S_RUN;
          end else begin
            // Zero-length shift sequences complete without touching q.
            if (!is_shift_op(op)) begin
              q_d   = direct_q;
              ser_d = direct_ser;
            end
            done_d = 1'b1;
          end
        end else if (en) begin
          q_d   = direct_q;
          ser_d = direct_ser;
        end
      end
      S_RUN: begin
        q_d   = sh_q;
        ser_d = sh_bit;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      q_q     <= RESET_VAL;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_q;
  assign busy    = (state_q == S_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal against an arithmetic reference model.
module tb_shift_register_universal;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  logic [7:0] mq;
  logic       mser;

  shift_register_universal #(
    .WIDTH     (8),
    .RESET_VAL (8'h00),
    .CNT_W     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .op      (op),
    .d       (d),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .start   (start),
    .count   (count),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one op applied to the model register using integer arithmetic.
  function automatic void model_step(input logic [2:0] o, input logic [7:0] dd,
                                     input logic sl, input logic sr);
    int v;
    int r;
    v = int'(mq);
    r = v;
    case (o)
      3'd1: r = int'(dd);
      3'd2: begin mser = ((v / HALF) % 2) != 0; r = (v * 2 + int'(sl)) % MOD; end
      3'd3: begin mser = (v % 2) != 0; r = v / 2 + int'(sr) * HALF; end
      3'd4: begin mser = ((v / HALF) % 2) != 0; r = (v * 2) % MOD + v / HALF; end
      3'd5: begin mser = (v % 2) != 0; r = v / 2 + (v % 2) * HALF; end
      3'd6: begin mser = (v % 2) != 0; r = v / 2 + (v / HALF) * HALF; end
      3'd7: r = 0;
      default: r = v;
    endcase
    mq = 8'(r);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; op = 3'd1; d = 8'hFF; start = 1'b0; count = '0;
    sin_l = 1'b0; sin_r = 1'b0;
    tick();
    tick();
    mq = 8'h00; mser = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL reset_ser got %b want 0", ser_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_direct;
    logic [2:0] ops [6] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd6, 3'd7};
    logic [7:0] ds  [6] = '{8'hA5, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    logic       sls [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ens [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exq [6] = '{8'hA5, 8'h4B, 8'h25, 8'h80, 8'hC0, 8'hC0};
    logic       exs [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      op = ops[i]; d = ds[i]; sin_l = sls[i]; sin_r = 1'b0; en = ens[i]; start = 1'b0;
      if (ens[i]) model_step(ops[i], ds[i], sls[i], 1'b0);
      tick();
      checks++; if (q !== exq[i]) begin errors++; $display("FAIL direct_q[%0d] got %h want %h", i, q, exq[i]); end
      checks++; if (ser_out !== exs[i]) begin errors++; $display("FAIL direct_ser[%0d] got %b want %b", i, ser_out, exs[i]); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL direct_flags[%0d] got busy=%b done=%b want 0 0", i, busy, done); end
    end
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); d = 8'($urandom); en = 1'($urandom);
      sin_l = 1'($urandom); sin_r = 1'($urandom); start = 1'b0;
      if (en) model_step(op, d, sin_l, sin_r);
      tick();
      checks++; if (q !== mq || ser_out !== mser) begin errors++; $display("FAIL direct_rand[%0d] got q=%h ser=%b want q=%h ser=%b", i, q, ser_out, mq, mser); end
    end
  endtask

  task automatic seq_case(input logic [2:0] sop, input int n, input logic [7:0] init,
                          input bit garbage);
    op = 3'd1; d = init; en = 1'b1; start = 1'b0;
    model_step(3'd1, init, 1'b0, 1'b0);
    tick();
    checks++; if (q !== mq) begin errors++; $display("FAIL seq_load got %h want %h", q, mq); end
    start = 1'b1; op = sop; count = 4'(n); en = 1'($urandom);
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== mq) begin
      errors++; $display("FAIL seq_launch got busy=%b done=%b q=%h want 1 0 %h", busy, done, q, mq);
    end
    for (int i = 1; i <= n; i++) begin
      start = garbage; count = garbage ? 4'd7 : 4'd0;
      op = garbage ? 3'($urandom_range(0, 7)) : sop;
      d = 8'($urandom); en = 1'($urandom); sin_l = 1'($urandom); sin_r = 1'($urandom);
      model_step(sop, 8'h00, sin_l, sin_r);
      tick();
      checks++; if (q !== mq || ser_out !== mser) begin
        errors++; $display("FAIL seq_step[%0d] got q=%h ser=%b want q=%h ser=%b", i, q, ser_out, mq, mser);
      end
      checks++; if (busy !== (i < n) || done !== (i == n)) begin
        errors++; $display("FAIL seq_flags[%0d] got busy=%b done=%b want %b %b", i, busy, done, i < n, i == n);
      end
    end
    start = 1'b0; en = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== mq) begin
      errors++; $display("FAIL seq_after got busy=%b done=%b q=%h want 0 0 %h", busy, done, q, mq);
    end
  endtask

  task automatic test_sequence;
    op = 3'd1; d = 8'h81; en = 1'b1; start = 1'b0;
    model_step(3'd1, 8'h81, 1'b0, 1'b0);
    tick();
    start = 1'b1; op = 3'd4; count = 4'd3; en = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rol_busy[%0d] got %b want 1", i, busy); end
      model_step(3'd4, 8'h00, 1'b0, 1'b0);
      tick();
    end
    checks++; if (q !== 8'h0C || q !== mq) begin errors++; $display("FAIL rol_q got %h want 0c", q); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ser_out !== 1'b0) begin
      errors++; $display("FAIL rol_done got done=%b busy=%b ser=%b want 1 0 0", done, busy, ser_out);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rol_done_pulse got %b want 0", done); end
  endtask

  task automatic test_edge;
    op = 3'd1; d = 8'h5A; en = 1'b1; start = 1'b0;
    model_step(3'd1, 8'h5A, 1'b0, 1'b0);
    tick();
    start = 1'b1; op = 3'd3; count = 4'd0; sin_r = 1'b1;
    tick();
    checks++; if (q !== 8'h5A || ser_out !== mser) begin
      errors++; $display("FAIL cnt0_q got q=%h ser=%b want 5a %b", q, ser_out, mser);
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cnt0_flags got done=%b busy=%b want 1 0", done, busy);
    end
    start = 1'b1; op = 3'd1; d = 8'h3C; count = 4'd5;
    model_step(3'd1, 8'h3C, 1'b0, 1'b0);
    tick();
    checks++; if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL start_load got q=%h done=%b busy=%b want 3c 1 0", q, done, busy);
    end
    start = 1'b0; en = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_load_after got done=%b busy=%b want 0 0", done, busy);
    end
    seq_case(3'd3, 3, 8'hC3, 1'b1);
  endtask

  task automatic test_back_to_back;
    op = 3'd1; d = 8'h96; en = 1'b1; start = 1'b0;
    model_step(3'd1, 8'h96, 1'b0, 1'b0);
    tick();
    start = 1'b1; op = 3'd5; count = 4'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_step(3'd5, 8'h00, 1'b0, 1'b0);
      tick();
    end
    checks++; if (done !== 1'b1 || q !== mq) begin
      errors++; $display("FAIL b2b_first got done=%b q=%h want 1 %h", done, q, mq);
    end
    start = 1'b1; op = 3'd4; count = 4'd1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    end
    model_step(3'd4, 8'h00, 1'b0, 1'b0);
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== mq || ser_out !== mser) begin
      errors++; $display("FAIL b2b_second got done=%b busy=%b q=%h ser=%b want 1 0 %h %b", done, busy, q, ser_out, mq, mser);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int seen_done;
    seen_done = 0;
    op = 3'd1; d = 8'hFF; en = 1'b1; start = 1'b0;
    model_step(3'd1, 8'hFF, 1'b0, 1'b0);
    tick();
    start = 1'b1; op = 3'd3; count = 4'd10; sin_r = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_step(3'd3, 8'h00, 1'b0, 1'b0);
      tick();
    end
    checks++; if (q !== 8'h0F || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre got q=%h busy=%b want 0f 1", q, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0;
    mq = 8'h00; mser = 1'b0;
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      errors++; $display("FAIL abort_reset got q=%h busy=%b done=%b ser=%b want 00 0 0 0", q, busy, done, ser_out);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    checks++; if (seen_done != 0) begin
      errors++; $display("FAIL abort_no_done got %0d active cycles want 0", seen_done);
    end
  endtask

  task automatic test_stream;
    logic [7:0] bits;
    bits = 8'b1011_0010;
    op = 3'd7; en = 1'b1; start = 1'b0;
    model_step(3'd7, 8'h00, 1'b0, 1'b0);
    tick();
    start = 1'b1; op = 3'd2; count = 4'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin_l = bits[7 - i];
      model_step(3'd2, 8'h00, sin_l, 1'b0);
      tick();
      checks++; if (q !== mq) begin errors++; $display("FAIL stream_q[%0d] got %h want %h", i, q, mq); end
    end
    checks++; if (q !== 8'hB2 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stream_final got q=%h done=%b busy=%b want b2 1 0", q, done, busy);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_random;
    for (int k = 0; k < 15; k++) begin
      seq_case(3'($urandom_range(2, 6)), int'($urandom_range(1, 15)), 8'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_direct();
    test_sequence();
    test_edge();
    test_back_to_back();
    test_abort();
    test_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
